// File: rtl/icache_linefill_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : icache_linefill_ctrl
// Purpose  : Assembles downstream read beats into an icache line, writes it to
//            the data RAM and pulses completion back to the owning MSHR entry.
// Revision : 1.0 - initial release
// ============================================================================
module icache_linefill_ctrl #(
  parameter int LINE_BEATS  = 4,
  parameter int BEAT_WIDTH  = 128,
  parameter int ENTRY_NUM   = 8,
  parameter int TXNID_WIDTH = 8,
  parameter int INDEX_WIDTH = 7
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             rxdat_vld,
  output logic                             rxdat_rdy,
  input  logic [TXNID_WIDTH-1:0]           rxdat_txnid,
  input  logic [BEAT_WIDTH-1:0]            rxdat_data,
  input  logic                             rxdat_last,
  output logic [$clog2(ENTRY_NUM)-1:0]     fill_entry_id,
  input  logic [INDEX_WIDTH-1:0]           fill_index,
  input  logic                             fill_way,
  output logic                             dataram_wr_vld,
  input  logic                             dataram_wr_rdy,
  output logic [INDEX_WIDTH-1:0]           dataram_wr_index,
  output logic                             dataram_wr_way,
  output logic [LINE_BEATS*BEAT_WIDTH-1:0] dataram_wr_data,
  output logic                             linefill_done,
  output logic [ENTRY_NUM-1:0]             linefill_done_oh,
  output logic                             protocol_err
);

  localparam int CNT_W = $clog2(LINE_BEATS);
  localparam int EID_W = $clog2(ENTRY_NUM);
  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(LINE_BEATS - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_WRITE   = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  state_t                               state_q, state_d;
  logic [CNT_W-1:0]                     beat_cnt_q, beat_cnt_d;
  logic [LINE_BEATS-1:0][BEAT_WIDTH-1:0] line_q, line_d;
  logic [TXNID_WIDTH-1:0]               txnid_q, txnid_d;
  logic [INDEX_WIDTH-1:0]               index_q, index_d;
  logic                                 way_q, way_d;
  logic                                 rdy_q, rdy_d;
  logic                                 err_q, err_d;

  logic accept;
  logic is_last_slot;
  logic txnid_mismatch;

  assign accept         = rxdat_vld && rdy_q;
  assign is_last_slot   = (beat_cnt_q == LAST_SLOT);
  assign txnid_mismatch = (state_q == ST_COLLECT) && (rxdat_txnid != txnid_q);

  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    line_d     = line_q;
    txnid_d    = txnid_q;
    index_d    = index_q;
    way_d      = way_q;
    // A bad beat is still stored and counted; only the flag is raised.
    err_d      = accept && ((rxdat_last != is_last_slot) || txnid_mismatch);

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          line_d[0]  = rxdat_data;
          txnid_d    = rxdat_txnid;
          beat_cnt_d = CNT_W'(1);
          state_d    = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (accept) begin
          line_d[beat_cnt_q] = rxdat_data;
          if (is_last_slot) begin
            beat_cnt_d = '0;
            index_d    = fill_index;
            way_d      = fill_way;
            state_d    = ST_WRITE;
          end else begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
          end
        end
      end
      ST_WRITE: begin
        if (dataram_wr_rdy) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Ready follows the next state so it is registered yet never late.
    rdy_d = (state_d == ST_IDLE) || (state_d == ST_COLLECT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      beat_cnt_q <= '0;
      line_q     <= '0;
      txnid_q    <= '0;
      index_q    <= '0;
      way_q      <= 1'b0;
      rdy_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      line_q     <= line_d;
      txnid_q    <= txnid_d;
      index_q    <= index_d;
      way_q      <= way_d;
      rdy_q      <= rdy_d;
      err_q      <= err_d;
    end
  end

  assign rxdat_rdy        = rdy_q;
  assign fill_entry_id    = txnid_q[EID_W-1:0];
  assign dataram_wr_vld   = (state_q == ST_WRITE);
  assign dataram_wr_index = index_q;
  assign dataram_wr_way   = way_q;
  assign dataram_wr_data  = line_q;
  assign linefill_done    = (state_q == ST_DONE);
  assign linefill_done_oh = (state_q == ST_DONE) ? (ENTRY_NUM'(1) << fill_entry_id) : '0;
  assign protocol_err     = err_q;

endmodule
`default_nettype wire

// File: tb/tb_icache_linefill_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_icache_linefill_ctrl
// Purpose  : Directed self-checking bench for icache_linefill_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_icache_linefill_ctrl;

  logic         clk;
  logic         rst;
  logic         rxdat_vld;
  logic         rxdat_rdy;
  logic [7:0]   rxdat_txnid;
  logic [127:0] rxdat_data;
  logic         rxdat_last;
  logic [2:0]   fill_entry_id;
  logic [6:0]   fill_index;
  logic         fill_way;
  logic         dataram_wr_vld;
  logic         dataram_wr_rdy;
  logic [6:0]   dataram_wr_index;
  logic         dataram_wr_way;
  logic [511:0] dataram_wr_data;
  logic         linefill_done;
  logic [7:0]   linefill_done_oh;
  logic         protocol_err;

  int tests;
  int fails;

  // Observations collected away from the clock edge
  int           err_cnt;
  int           done_cnt;
  int           wr_cnt;
  logic [511:0] last_wr_data;
  logic [6:0]   last_wr_index;
  logic         last_wr_way;
  logic [7:0]   last_oh;

  icache_linefill_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .rxdat_vld        (rxdat_vld),
    .rxdat_rdy        (rxdat_rdy),
    .rxdat_txnid      (rxdat_txnid),
    .rxdat_data       (rxdat_data),
    .rxdat_last       (rxdat_last),
    .fill_entry_id    (fill_entry_id),
    .fill_index       (fill_index),
    .fill_way         (fill_way),
    .dataram_wr_vld   (dataram_wr_vld),
    .dataram_wr_rdy   (dataram_wr_rdy),
    .dataram_wr_index (dataram_wr_index),
    .dataram_wr_way   (dataram_wr_way),
    .dataram_wr_data  (dataram_wr_data),
    .linefill_done    (linefill_done),
    .linefill_done_oh (linefill_done_oh),
    .protocol_err     (protocol_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (protocol_err) err_cnt = err_cnt + 1;
    if (linefill_done) begin
      done_cnt = done_cnt + 1;
      last_oh  = linefill_done_oh;
    end
    if (dataram_wr_vld && dataram_wr_rdy) begin
      wr_cnt        = wr_cnt + 1;
      last_wr_data  = dataram_wr_data;
      last_wr_index = dataram_wr_index;
      last_wr_way   = dataram_wr_way;
    end
  end

  task automatic clear_obs();
    err_cnt  = 0;
    done_cnt = 0;
    wr_cnt   = 0;
    last_oh  = '0;
    last_wr_data = '0;
  endtask

  // Offers one beat and returns 1 time unit after the edge that accepted it.
  task automatic send_beat(input logic [7:0] id, input logic [127:0] d, input logic last);
    int n;
    n = 0;
    rxdat_vld   = 1'b1;
    rxdat_txnid = id;
    rxdat_data  = d;
    rxdat_last  = last;
    while (!rxdat_rdy && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    tests++;
    if (rxdat_rdy !== 1'b1) begin
      fails++;
      $display("FAIL send_beat_timeout: rdy=%b required 1", rxdat_rdy);
    end
    @(posedge clk); #1;
    rxdat_vld  = 1'b0;
    rxdat_last = 1'b0;
  endtask

  task automatic wait_done(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      if (linefill_done) seen = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rxdat_vld = 1'b0; rxdat_txnid = '0; rxdat_data = '0; rxdat_last = 1'b0;
    fill_index = '0; fill_way = 1'b0; dataram_wr_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (rxdat_rdy !== 1'b0) begin fails++; $display("FAIL reset_rdy: got %b want 0", rxdat_rdy); end
    tests++;
    if (dataram_wr_vld !== 1'b0 || linefill_done !== 1'b0 || protocol_err !== 1'b0) begin
      fails++;
      $display("FAIL reset_pulses: wr_vld=%b done=%b err=%b want 0 0 0", dataram_wr_vld, linefill_done, protocol_err);
    end
    tests++;
    if (linefill_done_oh !== 8'h00 || fill_entry_id !== 3'd0) begin
      fails++;
      $display("FAIL reset_ids: oh=%h eid=%0d want 00 0", linefill_done_oh, fill_entry_id);
    end
    tests++;
    if (dataram_wr_index !== 7'd0 || dataram_wr_way !== 1'b0 || dataram_wr_data !== 512'd0) begin
      fails++;
      $display("FAIL reset_wr_fields: idx=%h way=%b data_nonzero=%b want 0 0 0", dataram_wr_index, dataram_wr_way, |dataram_wr_data);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    tests++;
    if (rxdat_rdy !== 1'b1) begin fails++; $display("FAIL reset_release_rdy: got %b want 1", rxdat_rdy); end
  endtask

  task automatic test_single_fill();
    logic [511:0] exp;
    exp = {128'hA3, 128'hA2, 128'hA1, 128'hA0};
    clear_obs();
    fill_index = 7'h12; fill_way = 1'b1; dataram_wr_rdy = 1'b1;
    send_beat(8'h05, 128'hA0, 1'b0);
    send_beat(8'h05, 128'hA1, 1'b0);
    send_beat(8'h05, 128'hA2, 1'b0);
    send_beat(8'h05, 128'hA3, 1'b1);
    // cycle N+1
    tests++;
    if (dataram_wr_vld !== 1'b1 || rxdat_rdy !== 1'b0) begin
      fails++;
      $display("FAIL single_write_cycle: wr_vld=%b rdy=%b want 1 0", dataram_wr_vld, rxdat_rdy);
    end
    tests++;
    if (dataram_wr_data !== exp) begin
      fails++;
      $display("FAIL single_data: got %h want %h", dataram_wr_data, exp);
    end
    tests++;
    if (dataram_wr_index !== 7'h12 || dataram_wr_way !== 1'b1 || fill_entry_id !== 3'd5) begin
      fails++;
      $display("FAIL single_idx_way: idx=%h way=%b eid=%0d want 12 1 5", dataram_wr_index, dataram_wr_way, fill_entry_id);
    end
    @(posedge clk); #1;  // cycle N+2
    tests++;
    if (linefill_done !== 1'b1 || linefill_done_oh !== 8'h20 || dataram_wr_vld !== 1'b0) begin
      fails++;
      $display("FAIL single_done: done=%b oh=%h wr_vld=%b want 1 20 0", linefill_done, linefill_done_oh, dataram_wr_vld);
    end
    @(posedge clk); #1;  // cycle N+3
    tests++;
    if (linefill_done !== 1'b0 || linefill_done_oh !== 8'h00 || rxdat_rdy !== 1'b1) begin
      fails++;
      $display("FAIL single_after_done: done=%b oh=%h rdy=%b want 0 00 1", linefill_done, linefill_done_oh, rxdat_rdy);
    end
    tests++;
    if (err_cnt !== 0 || done_cnt !== 1) begin
      fails++;
      $display("FAIL single_counts: err=%0d done=%0d want 0 1", err_cnt, done_cnt);
    end
  endtask

  task automatic test_backpressure();
    logic [511:0] exp;
    int bad;
    exp = {128'hB3, 128'hB2, 128'hB1, 128'hB0};
    clear_obs();
    fill_index = 7'h34; fill_way = 1'b0; dataram_wr_rdy = 1'b0;
    send_beat(8'h01, 128'hB0, 1'b0);
    send_beat(8'h01, 128'hB1, 1'b0);
    send_beat(8'h01, 128'hB2, 1'b0);
    send_beat(8'h01, 128'hB3, 1'b1);
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) dataram_wr_rdy = 1'b1;
      if (dataram_wr_vld !== 1'b1 || rxdat_rdy !== 1'b0 || dataram_wr_data !== exp ||
          dataram_wr_index !== 7'h34 || linefill_done !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL bp_hold: %0d bad cycles of 4, want 0", bad);
    end
    tests++;
    if (linefill_done !== 1'b1 || linefill_done_oh !== 8'h02) begin
      fails++;
      $display("FAIL bp_done: done=%b oh=%h want 1 02", linefill_done, linefill_done_oh);
    end
    tests++;
    if (wr_cnt !== 1 || last_wr_data !== exp) begin
      fails++;
      $display("FAIL bp_write: writes=%0d data=%h want 1 %h", wr_cnt, last_wr_data, exp);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_gapped_back_to_back();
    logic [511:0] exp1, exp2;
    bit seen;
    int c0, c1;
    exp1 = {128'hC3, 128'hC2, 128'hC1, 128'hC0};
    exp2 = {128'hD3, 128'hD2, 128'hD1, 128'hD0};
    clear_obs();
    fill_index = 7'h55; fill_way = 1'b1; dataram_wr_rdy = 1'b1;
    for (int b = 0; b < 4; b++) begin
      send_beat(8'h07, 128'hC0 + 128'(b), (b == 3));
      if (b != 3) begin
        repeat (2) @(posedge clk);
        #1;
      end
    end
    c0 = $time;
    send_beat(8'h03, 128'hD0, 1'b0);
    c1 = $time;
    // last beat at edge N; next line beat accepted at edge N+3
    tests++;
    if ((c1 - c0) != 30 || done_cnt !== 1) begin
      fails++;
      $display("FAIL b2b_accept_gap: delta=%0d done=%0d want 30 1", c1 - c0, done_cnt);
    end
    tests++;
    if (last_wr_data !== exp1 || last_wr_index !== 7'h55 || last_wr_way !== 1'b1 || last_oh !== 8'h80) begin
      fails++;
      $display("FAIL gapped_line: data=%h idx=%h way=%b oh=%h want %h 55 1 80",
               last_wr_data, last_wr_index, last_wr_way, last_oh, exp1);
    end
    fill_index = 7'h0A; fill_way = 1'b0;
    send_beat(8'h03, 128'hD1, 1'b0);
    send_beat(8'h03, 128'hD2, 1'b0);
    send_beat(8'h03, 128'hD3, 1'b1);
    wait_done(seen);
    tests++;
    if (!seen || linefill_done_oh !== 8'h08) begin
      fails++;
      $display("FAIL b2b_second_done: seen=%b oh=%h want 1 08", seen, linefill_done_oh);
    end
    tests++;
    if (last_wr_data !== exp2 || last_wr_index !== 7'h0A || err_cnt !== 0) begin
      fails++;
      $display("FAIL b2b_second_line: data=%h idx=%h err=%0d want %h 0a 0", last_wr_data, last_wr_index, err_cnt, exp2);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_protocol_err();
    bit seen;
    clear_obs();
    fill_index = 7'h21; fill_way = 1'b0; dataram_wr_rdy = 1'b1;
    send_beat(8'h02, 128'hE0, 1'b0);
    send_beat(8'h02, 128'hE1, 1'b1);
    tests++;
    if (protocol_err !== 1'b1) begin fails++; $display("FAIL err_early_last: err=%b want 1", protocol_err); end
    send_beat(8'h02, 128'hE2, 1'b0);
    tests++;
    if (protocol_err !== 1'b0 || dataram_wr_vld !== 1'b0) begin
      fails++;
      $display("FAIL err_not_ended: err=%b wr_vld=%b want 0 0", protocol_err, dataram_wr_vld);
    end
    send_beat(8'h02, 128'hE3, 1'b1);
    wait_done(seen);
    tests++;
    if (!seen || err_cnt !== 1 || linefill_done_oh !== 8'h04 ||
        last_wr_data !== {128'hE3, 128'hE2, 128'hE1, 128'hE0}) begin
      fails++;
      $display("FAIL err_last_line: seen=%b errs=%0d oh=%h data=%h want 1 1 04 E3E2E1E0",
               seen, err_cnt, linefill_done_oh, last_wr_data);
    end
    @(posedge clk); #1;
    clear_obs();
    send_beat(8'h04, 128'hF0, 1'b0);
    send_beat(8'h04, 128'hF1, 1'b0);
    send_beat(8'h0C, 128'hF2, 1'b0);
    tests++;
    if (protocol_err !== 1'b1) begin fails++; $display("FAIL err_txnid: err=%b want 1", protocol_err); end
    send_beat(8'h04, 128'hF3, 1'b1);
    wait_done(seen);
    tests++;
    if (!seen || err_cnt !== 1 || linefill_done_oh !== 8'h10 ||
        last_wr_data !== {128'hF3, 128'hF2, 128'hF1, 128'hF0}) begin
      fails++;
      $display("FAIL err_txnid_line: seen=%b errs=%0d oh=%h data=%h want 1 1 10 F3F2F1F0",
               seen, err_cnt, linefill_done_oh, last_wr_data);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_fill();
    bit seen;
    clear_obs();
    fill_index = 7'h3C; fill_way = 1'b1; dataram_wr_rdy = 1'b1;
    send_beat(8'h06, 128'h60, 1'b0);
    send_beat(8'h06, 128'h61, 1'b0);
    rst = 1'b1;
    #1;
    tests++;
    if (rxdat_rdy !== 1'b0 || dataram_wr_vld !== 1'b0 || fill_entry_id !== 3'd0) begin
      fails++;
      $display("FAIL midrst_async: rdy=%b wr_vld=%b eid=%0d want 0 0 0", rxdat_rdy, dataram_wr_vld, fill_entry_id);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    tests++;
    if (wr_cnt !== 0 || done_cnt !== 0) begin
      fails++;
      $display("FAIL midrst_abandon: writes=%0d dones=%0d want 0 0", wr_cnt, done_cnt);
    end
    send_beat(8'h01, 128'h70, 1'b0);
    send_beat(8'h01, 128'h71, 1'b0);
    send_beat(8'h01, 128'h72, 1'b0);
    send_beat(8'h01, 128'h73, 1'b1);
    wait_done(seen);
    tests++;
    if (!seen || linefill_done_oh !== 8'h02 || wr_cnt !== 1 || err_cnt !== 0 ||
        last_wr_data !== {128'h73, 128'h72, 128'h71, 128'h70} || last_wr_index !== 7'h3C) begin
      fails++;
      $display("FAIL midrst_new_line: seen=%b oh=%h writes=%0d errs=%0d idx=%h data=%h",
               seen, linefill_done_oh, wr_cnt, err_cnt, last_wr_index, last_wr_data);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    clear_obs();
    test_reset();
    test_single_fill();
    test_backpressure();
    test_gapped_back_to_back();
    test_protocol_err();
    test_reset_mid_fill();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
